// File: rtl/fifo_word_unpacker_pkg.sv
// fifo_word_unpacker_pkg: shared state type, default sizes and lowest-set-bit helper for the unpacker.
package fifo_unpack_pkg;
  typedef enum logic {IDLE, EMIT} unpack_state_t;
  localparam int WORD_BYTES_DEF = 4;
  localparam int BYTE_W_DEF = 8;
  localparam int MAX_BYTES = 8;
  // Mask is zero-extended to the largest supported word; callers truncate the index to their own width.
  function automatic logic [$clog2(MAX_BYTES)-1:0] lowest_set_idx(input logic [MAX_BYTES-1:0] mask);
    lowest_set_idx = '0;
    for (int i = MAX_BYTES - 1; i >= 0; i--) if (mask[i]) lowest_set_idx = $clog2(MAX_BYTES)'(i);
  endfunction
endpackage

// File: rtl/fifo_word_unpacker_if.sv
// fifo_word_unpacker_if: word stream in, byte FIFO write port out, grouped for the unpacker.
interface fifo_word_unpacker_if import fifo_unpack_pkg::*; #(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int BYTE_W = BYTE_W_DEF
);
  logic s_valid;
  logic s_ready;
  logic [WORD_BYTES*BYTE_W-1:0] s_data;
  logic [WORD_BYTES-1:0] s_keep;
  logic fifo_wr;
  logic [BYTE_W-1:0] fifo_din;
  logic fifo_full;
  logic busy;
  modport slave(input s_valid, s_data, s_keep, fifo_full, output s_ready, fifo_wr, fifo_din, busy);
  modport master(output s_valid, s_data, s_keep, fifo_full, input s_ready, fifo_wr, fifo_din, busy);
endinterface

// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: splits keep-masked words into one FIFO byte write per cycle, lowest byte first.
// Optional UNPACK_STATS_EN adds bytes_written / words_dropped counters.
module fifo_word_unpacker import fifo_unpack_pkg::*; #(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input logic clk,
  input logic rst,
  fifo_word_unpacker_if.slave bus
`ifdef UNPACK_STATS_EN
  ,
  output logic [15:0] bytes_written,
  output logic [7:0] words_dropped
`endif
);
  localparam int IDX_W = $clog2(WORD_BYTES);
  unpack_state_t state_q, state_d;
  logic [WORD_BYTES*BYTE_W-1:0] word_q, word_d;
  logic [WORD_BYTES-1:0] mask_q, mask_d, mask_rest;
  logic [IDX_W-1:0] cur;
  logic emit, wr, last, rdy, accept;
  always_comb begin
    cur = IDX_W'(lowest_set_idx(MAX_BYTES'(mask_q)));
    emit = state_q == EMIT;
    mask_rest = mask_q & ~(WORD_BYTES'(1) << cur);
    wr = emit && !bus.fifo_full;
    last = wr && mask_rest == '0;
    rdy = rst && (!emit || last);
    accept = bus.s_valid && rdy;
    word_d = accept ? bus.s_data : word_q;
    mask_d = accept ? bus.s_keep : wr ? mask_rest : mask_q;
    state_d = accept ? (|bus.s_keep ? EMIT : IDLE) : last ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      mask_q <= mask_d;
    end
  end
  assign bus.s_ready = rdy;
  assign bus.fifo_wr = wr;
  assign bus.fifo_din = |mask_q ? word_q[BYTE_W*int'(cur) +: BYTE_W] : '0;
  assign bus.busy = emit;
`ifdef UNPACK_STATS_EN
  logic [15:0] bytes_written_q, bytes_written_d;
  logic [7:0] words_dropped_q, words_dropped_d;
  always_comb begin
    bytes_written_d = bytes_written_q + 16'(wr);
    words_dropped_d = (accept && bus.s_keep == '0 && words_dropped_q != 8'hFF) ? words_dropped_q + 8'd1 : words_dropped_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bytes_written_q <= '0;
      words_dropped_q <= '0;
    end else begin
      bytes_written_q <= bytes_written_d;
      words_dropped_q <= words_dropped_d;
    end
  end
  assign bytes_written = bytes_written_q;
  assign words_dropped = words_dropped_q;
`endif
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb_fifo_word_unpacker: per-cycle vector table plus fill/drain and async-reset sequences against a 16-deep FIFO model.
module tb_fifo_word_unpacker;
  typedef struct {
    logic r, v;
    logic [31:0] d;
    logic [3:0] k;
    logic ff;
    logic e_rdy, e_wr;
    logic [7:0] e_din;
    logic e_busy;
  } vec_t;
  logic clk = 0;
  logic rst = 0;
  int errors = 0, checks = 0;
  logic use_model = 0;
  logic [7:0] q[$];
  logic [7:0] popped;
  logic got_pop;
  vec_t tbl[$];
  fifo_word_unpacker_if #(.WORD_BYTES(4), .BYTE_W(8)) u();
`ifdef UNPACK_STATS_EN
  logic [15:0] bytes_written;
  logic [7:0] words_dropped;
  fifo_word_unpacker #(.WORD_BYTES(4), .BYTE_W(8)) dut(.clk(clk), .rst(rst), .bus(u), .bytes_written(bytes_written), .words_dropped(words_dropped));
`else
  fifo_word_unpacker #(.WORD_BYTES(4), .BYTE_W(8)) dut(.clk(clk), .rst(rst), .bus(u));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, v, input logic [31:0] d, input logic [3:0] k, input logic ff, e_rdy, e_wr, input logic [7:0] e_din, input logic e_busy);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.k = k; t.ff = ff;
    t.e_rdy = e_rdy; t.e_wr = e_wr; t.e_din = e_din; t.e_busy = e_busy;
    tbl.push_back(t);
  endtask
  // One cycle: drive at negedge, sample 1 unit later; the model FIFO pops then pushes as at the next edge.
  task automatic step(input logic r, v, input logic [31:0] d, input logic [3:0] k, input logic ff, rd);
    @(negedge clk);
    rst = r; u.s_valid = v; u.s_data = d; u.s_keep = k;
    u.fifo_full = ff || (use_model && q.size() >= 16);
    #1;
    got_pop = 0;
    if (rd && q.size() > 0) begin popped = q.pop_front(); got_pop = 1; end
    if (u.fifo_wr) q.push_back(u.fifo_din);
  endtask
  initial begin
    int n, sent, npop;
    logic [7:0] exp_b;
    logic [31:0] words[5];
    u.s_valid = 0; u.s_data = '0; u.s_keep = '0; u.fifo_full = 0;
    add(0,0,32'h0,4'h0,0, 0,0,8'h00,0);
    add(1,1,32'hDDCCBBAA,4'hF,0, 1,0,8'h00,0);
    add(1,0,32'h0,4'h0,0, 0,1,8'hAA,1);
    add(1,0,32'h0,4'h0,0, 0,1,8'hBB,1);
    add(1,0,32'h0,4'h0,0, 0,1,8'hCC,1);
    add(1,0,32'h0,4'h0,0, 1,1,8'hDD,1);
    add(1,0,32'h0,4'h0,0, 1,0,8'h00,0);
    add(1,1,32'h03020100,4'hF,0, 1,0,8'h00,0);
    add(1,1,32'h07060504,4'hF,0, 0,1,8'h00,1);
    add(1,1,32'h07060504,4'hF,0, 0,1,8'h01,1);
    add(1,1,32'h07060504,4'hF,0, 0,1,8'h02,1);
    add(1,1,32'h07060504,4'hF,0, 1,1,8'h03,1);
    add(1,0,32'h0,4'h0,0, 0,1,8'h04,1);
    add(1,0,32'h0,4'h0,0, 0,1,8'h05,1);
    add(1,0,32'h0,4'h0,0, 0,1,8'h06,1);
    add(1,0,32'h0,4'h0,0, 1,1,8'h07,1);
    add(1,1,32'h44332211,4'hA,0, 1,0,8'h00,0);
    add(1,0,32'h0,4'h0,0, 0,1,8'h22,1);
    add(1,0,32'h0,4'h0,0, 1,1,8'h44,1);
    add(1,1,32'h12345678,4'h0,0, 1,0,8'h00,0);
    add(1,0,32'h0,4'h0,0, 1,0,8'h00,0);
    add(1,1,32'hDDCCBBAA,4'hF,0, 1,0,8'h00,0);
    add(1,0,32'h0,4'h0,0, 0,1,8'hAA,1);
    add(1,0,32'h0,4'h0,0, 0,1,8'hBB,1);
    for (int i = 0; i < 5; i++) add(1,0,32'h0,4'h0,1, 0,0,8'hCC,1);
    add(1,0,32'h0,4'h0,0, 0,1,8'hCC,1);
    add(1,0,32'h0,4'h0,0, 1,1,8'hDD,1);
    add(1,0,32'h0,4'h0,0, 1,0,8'h00,0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].ff, 0);
      chk($sformatf("vec%0d rdy/wr/din/busy", i), {u.s_ready, u.fifo_wr, u.fifo_din, u.busy},
          {tbl[i].e_rdy, tbl[i].e_wr, tbl[i].e_din, tbl[i].e_busy});
    end
    chk("table byte count", q.size(), 18);
    chk("stall readback", {q[14], q[15], q[16], q[17]}, 32'hAABBCCDD);
`ifdef UNPACK_STATS_EN
    chk("bytes_written", bytes_written, 16'd18);
    chk("words_dropped", words_dropped, 8'd1);
`endif
    // Fill the model FIFO with 5 full words, stall, then drain one entry per cycle.
    q.delete();
    use_model = 1;
    for (int i = 0; i < 5; i++) words[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    sent = 0; n = 0;
    while (!(sent == 5 && q.size() == 16) && n < 60) begin
      step(1, sent < 5, words[sent < 5 ? sent : 4], 4'hF, 0, 0);
      if (u.s_valid && u.s_ready) sent++;
      n++;
    end
    chk("fill reached 16", n < 60, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h0, 4'h0, 0, 0);
      chk("full stall rdy/wr/din/busy", {u.s_ready, u.fifo_wr, u.fifo_din, u.busy}, {1'b0, 1'b0, 8'h10, 1'b1});
    end
    npop = 0; n = 0; exp_b = 0;
    while (npop < 20 && n < 60) begin
      step(1, 0, 32'h0, 4'h0, 0, 1);
      if (got_pop) begin
        chk("drain order", popped, exp_b);
        exp_b++;
        npop++;
      end
      n++;
    end
    chk("drain count/empty/busy", {npop[7:0], 8'(q.size()), 7'd0, u.busy}, {8'd20, 8'd0, 8'd0});
    // Async reset in the middle of a word.
    q.delete();
    step(1, 1, 32'hDDCCBBAA, 4'hF, 0, 0);
    step(1, 0, 32'h0, 4'h0, 0, 0);
    step(1, 0, 32'h0, 4'h0, 0, 0);
    @(negedge clk);
    #1;
    chk("pre-reset byte", {u.fifo_wr, u.fifo_din}, {1'b1, 8'hCC});
    rst = 0;
    #1;
    chk("async reset outputs", {u.s_ready, u.fifo_wr, u.fifo_din, u.busy}, 11'h0);
    @(posedge clk);
    #2;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h0, 4'h0, 0, 0);
      chk("post-reset idle", {u.s_ready, u.fifo_wr, u.busy}, 3'b100);
    end
    step(1, 1, 32'h0000005A, 4'h1, 0, 0);
    chk("5A accept", {u.s_ready, u.fifo_wr}, 2'b10);
    step(1, 0, 32'h0, 4'h0, 0, 0);
    chk("5A write", {u.s_ready, u.fifo_wr, u.fifo_din, u.busy}, {1'b1, 1'b1, 8'h5A, 1'b1});
    step(1, 0, 32'h0, 4'h0, 0, 0);
    chk("5A done", {u.fifo_wr, u.busy}, 2'b00);
    chk("reset fifo contents", {8'(q.size()), q[0], q[1], q[2]}, {8'd3, 8'hAA, 8'hBB, 8'h5A});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
